eater_control: RTL and testbench

- Microcoded control sequencer for the 8-bit SAP-style CPU.
- Consumes the opcode from the instruction register and the {zero, carry} flag pair published by the ALU.
- Drives the 16-bit control word that gates every bus driver and register load, including the ALU's flag load, subtract and sum-output strobes.
- Sits on the other end of the ALU flag interface: the ALU produces flags, this block decides conditional jumps from them.

---
 rtl/eater_pkg.sv | 55 +++++
 rtl/microcode_rom.sv | 58 +++++
 rtl/eater_control.sv | 70 +++++++
 tb/tb_eater_control.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/eater_pkg.sv
// Shared opcodes, control-word bit map and fetch words for the SAP-style control sequencer.
package eater_pkg;

  typedef logic [15:0] ctrl_word_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned B_HLT = 15;
  localparam int unsigned B_MI  = 14;
  localparam int unsigned B_RI  = 13;
  localparam int unsigned B_RO  = 12;
  localparam int unsigned B_IO  = 11;
  localparam int unsigned B_II  = 10;
  localparam int unsigned B_AI  = 9;
  localparam int unsigned B_AO  = 8;
  localparam int unsigned B_EO  = 7;
  localparam int unsigned B_SU  = 6;
  localparam int unsigned B_BI  = 5;
  localparam int unsigned B_OI  = 4;
  localparam int unsigned B_CE  = 3;
  localparam int unsigned B_CO  = 2;
  localparam int unsigned B_J   = 1;
  localparam int unsigned B_FI  = 0;

  localparam ctrl_word_t C_HLT = 16'h8000;
  localparam ctrl_word_t C_MI  = 16'h4000;
  localparam ctrl_word_t C_RI  = 16'h2000;
  localparam ctrl_word_t C_RO  = 16'h1000;
  localparam ctrl_word_t C_IO  = 16'h0800;
  localparam ctrl_word_t C_II  = 16'h0400;
  localparam ctrl_word_t C_AI  = 16'h0200;
  localparam ctrl_word_t C_AO  = 16'h0100;
  localparam ctrl_word_t C_EO  = 16'h0080;
  localparam ctrl_word_t C_SU  = 16'h0040;
  localparam ctrl_word_t C_BI  = 16'h0020;
  localparam ctrl_word_t C_OI  = 16'h0010;
  localparam ctrl_word_t C_CE  = 16'h0008;
  localparam ctrl_word_t C_CO  = 16'h0004;
  localparam ctrl_word_t C_J   = 16'h0002;
  localparam ctrl_word_t C_FI  = 16'h0001;

  localparam ctrl_word_t FETCH_T0 = C_CO | C_MI;
  localparam ctrl_word_t FETCH_T1 = C_RO | C_II | C_CE;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> 16-bit control word.
module microcode_rom
  import eater_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [2:0] step,
  input  logic [1:0] flags,
  output logic [15:0] ctrl
);

  ctrl_word_t t2, t3, t4;

  always_comb begin
    t2 = '0;
    t3 = '0;
    t4 = '0;
    case (opcode)
      OP_LDA: begin
        t2 = C_IO | C_MI;
        t3 = C_RO | C_AI;
      end
      OP_ADD: begin
        t2 = C_IO | C_MI;
        t3 = C_RO | C_BI;
        t4 = C_EO | C_AI | C_FI;
      end
      OP_SUB: begin
        t2 = C_IO | C_MI;
        t3 = C_RO | C_BI;
        t4 = C_EO | C_AI | C_SU | C_FI;
      end
      OP_STA: begin
        t2 = C_IO | C_MI;
        t3 = C_AO | C_RI;
      end
      OP_LDI: t2 = C_IO | C_AI;
      OP_JMP: t2 = C_IO | C_J;
      // flags[0] = carry, flags[1] = zero
      OP_JC:  t2 = flags[0] ? (C_IO | C_J) : '0;
      OP_JZ:  t2 = flags[1] ? (C_IO | C_J) : '0;
      OP_OUT: t2 = C_AO | C_OI;
      OP_HLT: t2 = C_HLT;
      default: ;
    endcase
  end

  always_comb begin
    case (step)
      3'd0:    ctrl = FETCH_T0;
      3'd1:    ctrl = FETCH_T1;
      3'd2:    ctrl = t2;
      3'd3:    ctrl = t3;
      3'd4:    ctrl = t4;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/eater_control.sv
// Control sequencer top: step counter, halt register and output mux around the microcode ROM.
module eater_control
  import eater_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 5,
  parameter bit          EARLY_END = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  instr,
  input  logic [1:0]  flags,
  output logic [15:0] ctrl,
  output logic [2:0]  step,
  output logic        halted
);

  logic [2:0] step_q, step_d, step_nxt;
  logic       halted_q, halted_d;
  ctrl_word_t cur_word, next_word;
  logic       unused_operand;

  assign unused_operand = ^instr[3:0];
  assign step_nxt       = step_q + 3'd1;

  microcode_rom u_rom_cur (
    .opcode (instr[7:4]),
    .step   (step_q),
    .flags  (flags),
    .ctrl   (cur_word)
  );

  // Lookahead copy lets the counter skip trailing all-zero steps.
  microcode_rom u_rom_next (
    .opcode (instr[7:4]),
    .step   (step_nxt),
    .flags  (flags),
    .ctrl   (next_word)
  );

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (!halted_q) begin
      if (cur_word[B_HLT]) begin
        halted_d = 1'b1;
      end else if (step_q == 3'(NUM_STEPS - 1)) begin
        step_d = '0;
      end else if (EARLY_END && (step_q != 3'd0) && (next_word == '0)) begin
        step_d = '0;
      end else begin
        step_d = step_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  assign ctrl   = halted_q ? C_HLT : cur_word;
  assign step   = step_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_eater_control.sv
// Vector-table bench for eater_control with EARLY_END=1 and EARLY_END=0 instances.
module tb_eater_control;

  typedef struct {
    bit         sel;     // 0: early-end DUT, 1: full-length DUT
    bit         rst;
    logic [7:0] instr;
    logic [1:0] flags;
    bit         chk;
    logic [15:0] ctrl;
    logic [2:0] step;
    bit         halted;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, reset0 = 1'b1;
  logic [7:0]  instr = 8'h00, instr0 = 8'h00;
  logic [1:0]  flags = 2'b00, flags0 = 2'b00;
  logic [15:0] ctrl, ctrl0;
  logic [2:0]  step, step0;
  logic        halted, halted0;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  eater_control #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut (
    .clk    (clk),
    .reset  (reset),
    .instr  (instr),
    .flags  (flags),
    .ctrl   (ctrl),
    .step   (step),
    .halted (halted)
  );

  eater_control #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut0 (
    .clk    (clk),
    .reset  (reset0),
    .instr  (instr0),
    .flags  (flags0),
    .ctrl   (ctrl0),
    .step   (step0),
    .halted (halted0)
  );

  function automatic vec_t mk(bit sel, bit rst, logic [7:0] i, logic [1:0] f, bit chk,
                              logic [15:0] c, logic [2:0] s, bit h);
    vec_t x;
    x.sel = sel; x.rst = rst; x.instr = i; x.flags = f; x.chk = chk;
    x.ctrl = c; x.step = s; x.halted = h;
    return x;
  endfunction

  // One clock cycle: drive just after the edge, compare at the falling edge.
  task automatic run_vec(input vec_t x, input int idx);
    vec_t e;
    logic [15:0] ac;
    logic [2:0]  as;
    logic        ah;
    @(posedge clk);
    #1;
    if (x.sel) begin
      reset0 = x.rst; instr0 = x.instr; flags0 = x.flags;
    end else begin
      reset = x.rst; instr = x.instr; flags = x.flags;
    end
    if (x.chk) exp_q.push_back(x);
    @(negedge clk);
    if (x.chk) begin
      e  = exp_q.pop_front();
      ac = e.sel ? ctrl0 : ctrl;
      as = e.sel ? step0 : step;
      ah = e.sel ? halted0 : halted;
      total++;
      if (ac !== e.ctrl) begin
        bad++;
        $display("FAIL ctrl vec%0d: got %h want %h", idx, ac, e.ctrl);
      end
      total++;
      if (as !== e.step) begin
        bad++;
        $display("FAIL step vec%0d: got %0d want %0d", idx, as, e.step);
      end
      total++;
      if (ah !== e.halted) begin
        bad++;
        $display("FAIL halted vec%0d: got %0b want %0b", idx, ah, e.halted);
      end
    end
  endtask

  initial begin
    int n;
    // LDA 15
    tbl.push_back(mk(0, 1, 8'h1F, 2'b00, 0, 16'h0000, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h1F, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h1F, 2'b00, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h1F, 2'b00, 1, 16'h4800, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h1F, 2'b00, 1, 16'h1200, 3'd3, 0));
    // ADD
    tbl.push_back(mk(0, 0, 8'h2E, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h2E, 2'b00, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h2E, 2'b00, 1, 16'h4800, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h2E, 2'b00, 1, 16'h1020, 3'd3, 0));
    tbl.push_back(mk(0, 0, 8'h2E, 2'b00, 1, 16'h0281, 3'd4, 0));
    // SUB
    tbl.push_back(mk(0, 0, 8'h3E, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h3E, 2'b00, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h3E, 2'b00, 1, 16'h4800, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h3E, 2'b00, 1, 16'h1020, 3'd3, 0));
    tbl.push_back(mk(0, 0, 8'h3E, 2'b00, 1, 16'h02C1, 3'd4, 0));
    // JC taken, then untaken
    tbl.push_back(mk(0, 0, 8'h75, 2'b01, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h75, 2'b01, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h75, 2'b01, 1, 16'h0802, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h75, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h75, 2'b00, 1, 16'h1408, 3'd1, 0));
    // JZ taken, then untaken on carry-only
    tbl.push_back(mk(0, 0, 8'h83, 2'b10, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h83, 2'b10, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h83, 2'b10, 1, 16'h0802, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h83, 2'b01, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h83, 2'b01, 1, 16'h1408, 3'd1, 0));
    // JC with carry dropping during T2
    tbl.push_back(mk(0, 0, 8'h75, 2'b01, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h75, 2'b01, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h75, 2'b00, 1, 16'h0000, 3'd2, 0));
    // STA, LDI, JMP, OUT, 0x9/0xD as NOP
    tbl.push_back(mk(0, 0, 8'h4F, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h4F, 2'b00, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h4F, 2'b00, 1, 16'h4800, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h4F, 2'b00, 1, 16'h2100, 3'd3, 0));
    tbl.push_back(mk(0, 0, 8'h5A, 2'b11, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h5A, 2'b11, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h5A, 2'b11, 1, 16'h0A00, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h6A, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h6A, 2'b00, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'h6A, 2'b00, 1, 16'h0802, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'hE0, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'hE0, 2'b00, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'hE0, 2'b00, 1, 16'h0110, 3'd2, 0));
    tbl.push_back(mk(0, 0, 8'h9A, 2'b11, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'h9A, 2'b11, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'hD0, 2'b11, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'hD0, 2'b11, 1, 16'h1408, 3'd1, 0));
    // HLT
    tbl.push_back(mk(0, 0, 8'hF0, 2'b00, 1, 16'h4004, 3'd0, 0));
    tbl.push_back(mk(0, 0, 8'hF0, 2'b00, 1, 16'h1408, 3'd1, 0));
    tbl.push_back(mk(0, 0, 8'hF0, 2'b00, 1, 16'h8000, 3'd2, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);
    n = tbl.size();

    // Halted: frozen for 20 cycles despite toggling inputs
    for (int i = 0; i < 20; i++) begin
      run_vec(mk(0, 0, 8'($urandom), 2'($urandom), 1, 16'h8000, 3'd2, 1), n);
      n++;
    end
    // Reset while halted
    run_vec(mk(0, 1, 8'h1F, 2'b00, 1, 16'h8000, 3'd2, 1), n++);
    run_vec(mk(0, 0, 8'h1F, 2'b00, 1, 16'h4004, 3'd0, 0), n++);
    run_vec(mk(0, 0, 8'h1F, 2'b00, 1, 16'h1408, 3'd1, 0), n++);

    // Full-length sequencing with EARLY_END=0
    run_vec(mk(1, 1, 8'h00, 2'b00, 0, 16'h0000, 3'd0, 0), n++);
    for (int r = 0; r < 2; r++) begin
      run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h4004, 3'd0, 0), n++);
      run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h1408, 3'd1, 0), n++);
      run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h0000, 3'd2, 0), n++);
      run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h0000, 3'd3, 0), n++);
      if (r == 0) run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h0000, 3'd4, 0), n++);
    end
    // Mid-instruction reset at step 3: previous vector reached step 3; hold reset there
    run_vec(mk(1, 1, 8'h00, 2'b00, 1, 16'h0000, 3'd4, 0), n++);
    run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h4004, 3'd0, 0), n++);
    run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h1408, 3'd1, 0), n++);
    run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h0000, 3'd2, 0), n++);
    run_vec(mk(1, 1, 8'h00, 2'b00, 1, 16'h0000, 3'd3, 0), n++);
    run_vec(mk(1, 0, 8'h00, 2'b00, 1, 16'h4004, 3'd0, 0), n++);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
